// File: rtl/ip_layer_sequencer.sv
// Protocol-stack sequencer: validates a layer descriptor, then issues one header-generator
// start per layer (current + next protocol) and waits for each completion.
module ip_layer_sequencer #(
    parameter int unsigned MAX_LAYERS = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*MAX_LAYERS-1:0] desc_layers,
    input  logic [3:0]              desc_count,
    input  logic                    desc_vld,
    output logic                    desc_rdy,
    output logic                    gen_start,
    output logic [7:0]              gen_proto,
    output logic [7:0]              gen_next,
    output logic [2:0]              gen_layer,
    input  logic                    gen_done,
    output logic                    pkt_done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StIssue = 2'd2;
    localparam logic [1:0] StWait  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [8*MAX_LAYERS-1:0] layer_q, layer_d;
    logic [3:0]              count_q, count_d;
    logic [2:0]              idx_q, idx_d;
    logic [CW-1:0]           tmr_q, tmr_d;
    logic                    desc_rdy_q, busy_q;
    logic                    gen_start_q, gen_start_d;
    logic                    pkt_done_q, pkt_done_d;
    logic                    err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [7:0]              gen_proto_q, gen_proto_d;
    logic [7:0]              gen_next_q, gen_next_d;
    logic [2:0]              gen_layer_q;
    logic                    bad_count, bad_proto, bad_order, last;
    logic [31:0]             count_w, next_idx;
    logic [7:0]              cur, prev;

    function automatic logic is_supported(input logic [7:0] p);
        return p inside {8'd1, 8'd4, 8'd6, 8'd17, 8'd41, 8'd58, 8'd97, 8'd255};
    endfunction

    function automatic logic is_tunnel(input logic [7:0] p);
        return p inside {8'd4, 8'd41, 8'd97};
    endfunction

    function automatic logic is_ip(input logic [7:0] p);
        return p inside {8'd4, 8'd41};
    endfunction

    function automatic logic [7:0] layer_at(input logic [8*MAX_LAYERS-1:0] v,
                                            input logic [31:0] i);
        logic [7:0] r;
        r = 8'h00;
        for (int unsigned k = 0; k < MAX_LAYERS; k++) begin
            if (i == k) r = v[8*k +: 8];
        end
        return r;
    endfunction

    assign count_w   = 32'(count_q);
    assign bad_count = (count_q == 4'd0) || (count_w > MAX_LAYERS);
    assign last      = ((32'(idx_q) + 32'd1) == count_w);

    // Only layers below the latched count take part in validation.
    always_comb begin
        bad_proto = 1'b0;
        bad_order = 1'b0;
        cur       = 8'h00;
        prev      = 8'h00;
        for (int unsigned k = 0; k < MAX_LAYERS; k++) begin
            cur = layer_q[8*k +: 8];
            if (k < count_w) begin
                if (!is_supported(cur)) bad_proto = 1'b1;
                if ((k + 1 < count_w) && !is_tunnel(cur)) bad_order = 1'b1;
                if ((k != 0) && (cur == 8'd97) && !is_ip(prev)) bad_order = 1'b1;
            end
            prev = cur;
        end
    end

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        count_d     = count_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        gen_start_d = 1'b0;
        pkt_done_d  = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            StIdle: begin
                if (desc_vld && desc_rdy_q) begin
                    layer_d = desc_layers;
                    count_d = desc_count;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StIdle;
                err_d   = 1'b1;
                if (bad_count) begin
                    err_code_d = 2'd0;
                end else if (bad_proto) begin
                    err_code_d = 2'd1;
                end else if (bad_order) begin
                    err_code_d = 2'd2;
                end else begin
                    err_d       = 1'b0;
                    idx_d       = 3'd0;
                    gen_start_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                tmr_d = tmr_q + CW'(1);
                // A completion on the final timeout cycle still counts as success.
                if (gen_done) begin
                    if (last) begin
                        pkt_done_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        idx_d       = idx_q + 3'd1;
                        gen_start_d = 1'b1;
                        state_d     = StIssue;
                    end
                end else if (tmr_q == CW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Generator fields are computed one cycle early so they are registered with the start pulse.
    always_comb begin
        gen_proto_d = gen_proto_q;
        gen_next_d  = gen_next_q;
        next_idx    = 32'(idx_d) + 32'd1;
        if (gen_start_d) begin
            gen_proto_d = layer_at(layer_q, 32'(idx_d));
            gen_next_d  = (next_idx == count_w) ? 8'hFF : layer_at(layer_q, next_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            layer_q     <= '0;
            count_q     <= 4'd0;
            idx_q       <= 3'd0;
            tmr_q       <= '0;
            desc_rdy_q  <= 1'b0;
            busy_q      <= 1'b0;
            gen_start_q <= 1'b0;
            gen_proto_q <= 8'h00;
            gen_next_q  <= 8'h00;
            gen_layer_q <= 3'd0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            desc_rdy_q  <= (state_d == StIdle);
            busy_q      <= (state_d != StIdle);
            gen_start_q <= gen_start_d;
            gen_proto_q <= gen_proto_d;
            gen_next_q  <= gen_next_d;
            if (gen_start_d) gen_layer_q <= idx_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign desc_rdy  = desc_rdy_q;
    assign busy      = busy_q;
    assign gen_start = gen_start_q;
    assign gen_proto = gen_proto_q;
    assign gen_next  = gen_next_q;
    assign gen_layer = gen_layer_q;
    assign pkt_done  = pkt_done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
